wfg_stim_mem_arb: RTL and testbench

//  Arbiter/sequencer for the single-port stimulus SRAM (OpenRAM-style, 1-cycle read latency).

---
 rtl/wfg_stim_mem_arb.sv | 146 ++++++++++++++
 tb/tb_wfg_stim_mem_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_stim_mem_arb.sv
// Round-robin sequencer for the single-port stimulus SRAM.
// Shares the port between the stimulus reader and the host bus.
module wfg_stim_mem_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stim_req_i,
    input  logic [ADDR_W-1:0]   stim_addr_i,
    output logic                stim_ack_o,
    output logic [DATA_W-1:0]   stim_rdata_o,
    input  logic                host_req_i,
    input  logic                host_we_i,
    input  logic [DATA_W/8-1:0] host_sel_i,
    input  logic [ADDR_W-1:0]   host_addr_i,
    input  logic [DATA_W-1:0]   host_wdata_i,
    output logic                host_ack_o,
    output logic [DATA_W-1:0]   host_rdata_o,
    output logic                busy_o,
    output logic                csb0,
    output logic                web0,
    output logic [DATA_W/8-1:0] wmask0,
    output logic [ADDR_W-1:0]   addr0,
    output logic [DATA_W-1:0]   din0,
    input  logic [DATA_W-1:0]   dout0
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        ACK
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              gnt_host;
    logic              gnt_host_nx;
    logic              we_q;
    logic              we_nx;
    logic              rr_last;
    logic              rr_nx;
    logic              csb_nx;
    logic              web_nx;
    logic [SEL_W-1:0]  wmask_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] din_nx;
    logic              stim_ack_nx;
    logic              host_ack_nx;
    logic [DATA_W-1:0] stim_rdata_nx;
    logic [DATA_W-1:0] host_rdata_nx;
    logic              pick_host;
    logic              host_wr;

    // rr_last = 1 means the host had the last grant
    assign pick_host = host_req_i && (!stim_req_i || !rr_last);
    assign host_wr   = pick_host && host_we_i;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt_host     <= 1'b0;
            we_q         <= 1'b0;
            rr_last      <= 1'b1;
            csb0         <= 1'b1;
            web0         <= 1'b1;
            wmask0       <= '0;
            addr0        <= '0;
            din0         <= '0;
            stim_ack_o   <= 1'b0;
            host_ack_o   <= 1'b0;
            stim_rdata_o <= '0;
            host_rdata_o <= '0;
        end else begin
            state        <= state_nx;
            gnt_host     <= gnt_host_nx;
            we_q         <= we_nx;
            rr_last      <= rr_nx;
            csb0         <= csb_nx;
            web0         <= web_nx;
            wmask0       <= wmask_nx;
            addr0        <= addr_nx;
            din0         <= din_nx;
            stim_ack_o   <= stim_ack_nx;
            host_ack_o   <= host_ack_nx;
            stim_rdata_o <= stim_rdata_nx;
            host_rdata_o <= host_rdata_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        gnt_host_nx   = gnt_host;
        we_nx         = we_q;
        rr_nx         = rr_last;
        csb_nx        = csb0;
        web_nx        = web0;
        wmask_nx      = wmask0;
        addr_nx       = addr0;
        din_nx        = din0;
        stim_ack_nx   = 1'b0;
        host_ack_nx   = 1'b0;
        stim_rdata_nx = stim_rdata_o;
        host_rdata_nx = host_rdata_o;
        unique case (state)
            IDLE: begin
                if (stim_req_i || host_req_i) begin
                    gnt_host_nx = pick_host;
                    rr_nx       = pick_host;
                    we_nx       = host_wr;
                    csb_nx      = 1'b0;
                    web_nx      = ~host_wr;
                    wmask_nx    = host_wr ? host_sel_i : '0;
                    addr_nx     = pick_host ? host_addr_i : stim_addr_i;
                    din_nx      = host_wr ? host_wdata_i : '0;
                    state_nx    = CMD;
                end
            end
            CMD: begin
                csb_nx   = 1'b1;
                web_nx   = 1'b1;
                wmask_nx = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                // dout0 is valid now, one cycle after the read strobe
                if (!we_q && gnt_host) host_rdata_nx = dout0;
                if (!we_q && !gnt_host) stim_rdata_nx = dout0;
                stim_ack_nx = !gnt_host;
                host_ack_nx = gnt_host;
                state_nx    = ACK;
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wfg_stim_mem_arb.sv
// Bench for wfg_stim_mem_arb: behavioural SRAM, vector table,
// scoreboard of expected acks, plus timing corner sequences.
module tb_wfg_stim_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stim_req = 1'b0;
    logic [9:0]  stim_addr = '0;
    logic        stim_ack;
    logic [31:0] stim_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [3:0]  host_sel = '0;
    logic [9:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        busy;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [9:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0 = '0;

    wfg_stim_mem_arb #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stim_req_i(stim_req),
        .stim_addr_i(stim_addr),
        .stim_ack_o(stim_ack),
        .stim_rdata_o(stim_rdata),
        .host_req_i(host_req),
        .host_we_i(host_we),
        .host_sel_i(host_sel),
        .host_addr_i(host_addr),
        .host_wdata_i(host_wdata),
        .host_ack_o(host_ack),
        .host_rdata_o(host_rdata),
        .busy_o(busy),
        .csb0(csb0),
        .web0(web0),
        .wmask0(wmask0),
        .addr0(addr0),
        .din0(din0),
        .dout0(dout0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    typedef struct {
        logic        host;
        logic        we;
        logic [3:0]  sel;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        host;
        logic        rd;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs [17];
    sb_t         sb [$];
    int          ack_cyc [$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_stim = '0;
    logic [31:0] m_host = '0;
    int          c;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic collect(input int nacks, input int budget);
        int  got;
        sb_t e;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            if (nacks > 0 && got == nacks) break;
            @(negedge clk);
            if (stim_ack || host_ack) begin
                got++;
                ack_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(stim_ack | host_ack), 0);
                end else begin
                    e = sb.pop_front();
                    chk("single_ack", 32'(stim_ack & host_ack), 0);
                    chk("ack_port", 32'(host_ack), 32'(e.host));
                    if (e.rd && e.host) m_host = e.data;
                    if (e.rd && !e.host) m_stim = e.data;
                    chk("stim_rdata", stim_rdata, m_stim);
                    chk("host_rdata", host_rdata, m_host);
                end
            end
        end
        chk("ack_count", 32'(got), 32'(nacks));
    endtask

    task automatic access(input vec_t v);
        sb.push_back('{v.host, !v.we, v.exp});
        ack_cyc.delete();
        @(posedge clk);
        #1;
        c = cyc;
        if (v.host) begin
            host_req   = 1'b1;
            host_we    = v.we;
            host_sel   = v.sel;
            host_addr  = v.addr;
            host_wdata = v.wdata;
        end else begin
            stim_req  = 1'b1;
            stim_addr = v.addr;
        end
        collect(1, 12);
        if (ack_cyc.size() > 0) chk("latency", 32'(ack_cyc[0] - c), 3);
        @(posedge clk);
        #1;
        host_req = 1'b0;
        stim_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        stim_req = 1'b0;
        host_req = 1'b0;
        host_we  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_stim = '0;
        m_host = '0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 4'hF, 10'h005, 32'hCAFE0001, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 4'hF, 10'h3FF, 32'hFFFFFFFF, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'h5, 10'h3FF, 32'hA5A5A5A5, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0, 32'hFFA5FFA5};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 10'h3FF, 32'h0, 32'hFFA5FFA5};
        vecs[5]  = '{1'b1, 1'b1, 4'h0, 10'h3FF, 32'h12345678, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 10'h3FF, 32'h0, 32'hFFA5FFA5};
        vecs[7]  = '{1'b1, 1'b1, 4'hF, 10'h000, 32'h00000000, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 4'hA, 10'h000, 32'hDEADBEEF, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 4'h0, 10'h000, 32'h0, 32'hDE00BE00};
        vecs[10] = '{1'b1, 1'b1, 4'hF, 10'h001, 32'h11223344, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 10'h001, 32'h0, 32'h11223344};
        vecs[12] = '{1'b1, 1'b1, 4'hC, 10'h001, 32'hAABBCCDD, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 4'h0, 10'h001, 32'h0, 32'hAABB3344};
        vecs[14] = '{1'b1, 1'b1, 4'hF, 10'h002, 32'h55667788, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 4'hF, 10'h010, 32'h01010101, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 4'h0, 10'h002, 32'h0, 32'h55667788};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_csb0", 32'(csb0), 1);
        chk("rst_web0", 32'(web0), 1);
        chk("rst_wmask0", 32'(wmask0), 0);
        chk("rst_addr0", 32'(addr0), 0);
        chk("rst_din0", din0, 0);
        chk("rst_stim_ack", 32'(stim_ack), 0);
        chk("rst_host_ack", 32'(host_ack), 0);
        chk("rst_stim_rdata", stim_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) access(vecs[i]);

        // T1: stim read strobe timing
        sb.push_back('{1'b0, 1'b1, 32'hCAFE0001});
        ack_cyc.delete();
        @(posedge clk);
        #1;
        c = cyc;
        stim_req  = 1'b1;
        stim_addr = 10'h005;
        @(negedge clk);
        chk("t1_idle_csb0", 32'(csb0), 1);
        @(negedge clk);
        chk("t1_cmd_csb0", 32'(csb0), 0);
        chk("t1_cmd_web0", 32'(web0), 1);
        chk("t1_cmd_wmask0", 32'(wmask0), 0);
        chk("t1_cmd_addr0", 32'(addr0), 32'h005);
        collect(1, 6);
        if (ack_cyc.size() > 0) chk("t1_ack_cyc", 32'(ack_cyc[0] - c), 3);
        @(posedge clk);
        #1;
        stim_req = 1'b0;

        // T4: stim held high, addresses 0,1,2
        sb.push_back('{1'b0, 1'b1, 32'hDE00BE00});
        sb.push_back('{1'b0, 1'b1, 32'hAABB3344});
        sb.push_back('{1'b0, 1'b1, 32'h55667788});
        ack_cyc.delete();
        @(posedge clk);
        #1;
        stim_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stim_addr = 10'(k);
            collect(1, 12);
            @(posedge clk);
            #1;
        end
        stim_req = 1'b0;
        if (ack_cyc.size() == 3) begin
            chk("t4_gap01", 32'(ack_cyc[1] - ack_cyc[0]), 4);
            chk("t4_gap12", 32'(ack_cyc[2] - ack_cyc[1]), 4);
        end

        // T3: tie after reset, then alternating grants
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{1'b0, 1'b1, 32'hCAFE0001});
            sb.push_back('{1'b1, 1'b1, 32'hFFA5FFA5});
        end
        ack_cyc.delete();
        @(posedge clk);
        #1;
        c = cyc;
        stim_req  = 1'b1;
        stim_addr = 10'h005;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 10'h3FF;
        collect(4, 24);
        @(posedge clk);
        #1;
        stim_req = 1'b0;
        host_req = 1'b0;
        if (ack_cyc.size() == 4) begin
            chk("t3_s1_cyc", 32'(ack_cyc[0] - c), 3);
            chk("t3_h1_cyc", 32'(ack_cyc[1] - c), 7);
            chk("t3_s2_cyc", 32'(ack_cyc[2] - c), 11);
            chk("t3_h2_cyc", 32'(ack_cyc[3] - c), 15);
        end

        // T5: reset during CMD of a host write
        @(posedge clk);
        #1;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_sel   = 4'hF;
        host_addr  = 10'h010;
        host_wdata = 32'h77777777;
        @(negedge clk);
        @(negedge clk);
        chk("t5_cmd_csb0", 32'(csb0), 0);
        chk("t5_cmd_web0", 32'(web0), 0);
        chk("t5_cmd_wmask0", 32'(wmask0), 32'hF);
        chk("t5_cmd_din0", din0, 32'h77777777);
        chk("t5_cmd_addr0", 32'(addr0), 32'h010);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_csb0", 32'(csb0), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ack", 32'(host_ack), 0);
        host_req = 1'b0;
        host_we  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_stim = '0;
        m_host = '0;
        ack_cyc.delete();
        collect(0, 6);
        chk("t5_busy_after", 32'(busy), 0);
        access('{1'b1, 1'b0, 4'h0, 10'h010, 32'h0, 32'h01010101});

        // T6: request dropped during WAIT
        sb.push_back('{1'b0, 1'b1, 32'hCAFE0001});
        ack_cyc.delete();
        @(posedge clk);
        #1;
        c = cyc;
        stim_req  = 1'b1;
        stim_addr = 10'h005;
        repeat (3) @(negedge clk);
        stim_req = 1'b0;
        collect(1, 6);
        if (ack_cyc.size() > 0) chk("t6_ack_cyc", 32'(ack_cyc[0] - c), 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_grant", 32'(busy | stim_ack | host_ack), 0);
        end

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
